// File: rtl/axi4lite_palindrome_counter_slave.sv
// Purpose : AXI4-Lite register slave; counts DATA words that are bit-palindromes over PAL_WIDTH LSBs.
// Latency : write commit 1 cycle after AW+W latched, BVALID the cycle after; read data 1 cycle after AR.
// Backpressure: one write and one read outstanding; BVALID/RVALID hold until BREADY/RREADY.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN   clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*  write address, data and response channels (BRESP always OKAY)
//   S_AXI_AR* / S_AXI_R*         read address and data channels (RRESP always OKAY)
//   pal_hit                      one-cycle pulse when a palindromic word is counted
//
// Register map (select = addr[3:2]):
//   0x0 CTRL  RW  bit0 EN, bit1 CLR (write-1 pulse, reads 0)
//   0x4 DATA  RW  last written word
//   0x8 COUNT RO  palindromic-word count (saturating)
//   0xC TOTAL RO  evaluated-word count (saturating)
module axi4lite_palindrome_counter_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,  // only 32 is supported
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int PAL_WIDTH          = 32   // 1..32
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              pal_hit
);

    localparam logic [1:0]  SEL_CTRL  = 2'd0;
    localparam logic [1:0]  SEL_DATA  = 2'd1;
    localparam logic [1:0]  SEL_COUNT = 2'd2;
    localparam logic [1:0]  SEL_TOTAL = 2'd3;
    localparam logic [31:0] SAT       = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // Low during reset and for the first cycle after release, so no READY
    // is ever offered while the reset is still being distributed.
    logic        live_q;

    // Write channel state
    wstate_t     wstate_q, wstate_d;
    logic        aw_lat_q, aw_lat_d;
    logic        w_lat_q, w_lat_d;
    logic [1:0]  awsel_q, awsel_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        commit;

    // Read channel state
    rstate_t     rstate_q, rstate_d;
    logic [31:0] rdata_q, rdata_d;

    // Register file and evaluation pipeline
    logic        ctrl_en_q, ctrl_en_d;
    logic [31:0] data_q, data_d;
    logic [31:0] count_q, count_d;
    logic [31:0] total_q, total_d;
    logic        eval_vld_q, eval_vld_d;
    logic        eval_hit_q, eval_hit_d;
    logic        pal_hit_q, pal_hit_d;
    logic        clr;

    logic [31:0]          data_merged;
    logic [PAL_WIDTH-1:0] pal_rev;
    logic                 pal_ok;

    // Protection bits and the byte-offset address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res[7:0]   = strb[0] ? new_w[7:0]   : old_w[7:0];
        res[15:8]  = strb[1] ? new_w[15:8]  : old_w[15:8];
        res[23:16] = strb[2] ? new_w[23:16] : old_w[23:16];
        res[31:24] = strb[3] ? new_w[31:24] : old_w[31:24];
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Write FSM: AW and W are latched independently in W_IDLE, in either
    // order or together; the register update happens in W_COMMIT.
    // ------------------------------------------------------------------
    always_comb begin
        wstate_d      = wstate_q;
        aw_lat_d      = aw_lat_q;
        w_lat_d       = w_lat_q;
        awsel_d       = awsel_q;
        wdat_d        = wdat_q;
        wstrb_d       = wstrb_q;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        commit        = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                S_AXI_AWREADY = live_q && !aw_lat_q;
                S_AXI_WREADY  = live_q && !w_lat_q;
                if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                    aw_lat_d = 1'b1;
                    awsel_d  = S_AXI_AWADDR[3:2];
                end
                if (S_AXI_WVALID && S_AXI_WREADY) begin
                    w_lat_d = 1'b1;
                    wdat_d  = S_AXI_WDATA;
                    wstrb_d = S_AXI_WSTRB;
                end
                if (aw_lat_d && w_lat_d) begin
                    wstate_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                commit   = 1'b1;
                aw_lat_d = 1'b0;
                w_lat_d  = 1'b0;
                wstate_d = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Register update and palindrome evaluation
    // ------------------------------------------------------------------
    assign data_merged = merge_bytes(data_q, wdat_q, wstrb_q);
    assign pal_rev     = {<<{data_merged[PAL_WIDTH-1:0]}};
    assign pal_ok      = (data_merged[PAL_WIDTH-1:0] == pal_rev);

    always_comb begin
        ctrl_en_d  = ctrl_en_q;
        data_d     = data_q;
        eval_vld_d = 1'b0;
        eval_hit_d = 1'b0;
        clr        = 1'b0;
        if (commit && awsel_q == SEL_CTRL && wstrb_q[0]) begin
            ctrl_en_d = wdat_q[0];
            clr       = wdat_q[1];
        end
        // EN is sampled before this commit, so a CTRL write cannot affect
        // the evaluation of a DATA write committed on the same edge.
        if (commit && awsel_q == SEL_DATA) begin
            data_d     = data_merged;
            eval_vld_d = ctrl_en_q;
            eval_hit_d = ctrl_en_q && pal_ok;
        end
    end

    always_comb begin
        count_d   = count_q;
        total_d   = total_q;
        pal_hit_d = 1'b0;
        if (clr) begin
            // Clear wins over an increment landing on the same edge.
            count_d = 32'd0;
            total_d = 32'd0;
        end else if (eval_vld_q) begin
            if (total_q != SAT) begin
                total_d = total_q + 32'd1;
            end
            if (eval_hit_q) begin
                pal_hit_d = 1'b1;
                if (count_q != SAT) begin
                    count_d = count_q + 32'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: RDATA is captured on the AR handshake edge from the
    // register values as they were before that edge.
    // ------------------------------------------------------------------
    always_comb begin
        rstate_d      = rstate_q;
        rdata_d       = rdata_q;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        unique case (rstate_q)
            R_IDLE: begin
                S_AXI_ARREADY = live_q;
                if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                    rstate_d = R_DATA;
                    unique case (S_AXI_ARADDR[3:2])
                        SEL_CTRL:  rdata_d = {31'd0, ctrl_en_q};
                        SEL_DATA:  rdata_d = data_q;
                        SEL_COUNT: rdata_d = count_q;
                        SEL_TOTAL: rdata_d = total_q;
                        default:   rdata_d = 32'd0;
                    endcase
                end
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            live_q     <= 1'b0;
            wstate_q   <= W_IDLE;
            aw_lat_q   <= 1'b0;
            w_lat_q    <= 1'b0;
            awsel_q    <= 2'd0;
            wdat_q     <= 32'd0;
            wstrb_q    <= 4'd0;
            rstate_q   <= R_IDLE;
            rdata_q    <= 32'd0;
            ctrl_en_q  <= 1'b0;
            data_q     <= 32'd0;
            count_q    <= 32'd0;
            total_q    <= 32'd0;
            eval_vld_q <= 1'b0;
            eval_hit_q <= 1'b0;
            pal_hit_q  <= 1'b0;
        end else begin
            live_q     <= 1'b1;
            wstate_q   <= wstate_d;
            aw_lat_q   <= aw_lat_d;
            w_lat_q    <= w_lat_d;
            awsel_q    <= awsel_d;
            wdat_q     <= wdat_d;
            wstrb_q    <= wstrb_d;
            rstate_q   <= rstate_d;
            rdata_q    <= rdata_d;
            ctrl_en_q  <= ctrl_en_d;
            data_q     <= data_d;
            count_q    <= count_d;
            total_q    <= total_d;
            eval_vld_q <= eval_vld_d;
            eval_hit_q <= eval_hit_d;
            pal_hit_q  <= pal_hit_d;
        end
    end

    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;
    assign S_AXI_RDATA = rdata_q;
    assign pal_hit     = pal_hit_q;

endmodule
